// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: owns the single-port instruction memory. After reset it
// holds the CPU stalled while a program is streamed in from word 0 upward,
// then serves fetches. A load arriving at runtime pre-empts fetch, rewrites
// the program and restarts the CPU at PC 0.
module imem_load_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_valid,
    output logic              cpu_stall,
    output logic              pc_restart,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   load_count,
    output logic              boot_done,
    output logic              load_overflow
);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              pc_restart_q, pc_restart_d;
    logic              boot_done_q, boot_done_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] instr_hold_q, instr_hold_d;

    logic [ADDR_W-1:0] wr_ptr;
    logic              load_acc;
    logic              load_end;
    logic              fetch_acc;
    logic              reload;
    logic              unused_fetch_bits;

    // The write pointer and the word count advance together and are both
    // cleared on LOAD entry, so the pointer is simply the count's low bits.
    assign wr_ptr    = count_q[ADDR_W-1:0];
    assign load_acc  = (state_q == ST_LOAD) && !reset && load_valid;
    assign load_end  = load_acc && (load_last || (wr_ptr == '1));
    assign fetch_acc = (state_q == ST_RUN) && !reset && fetch_req;
    assign reload    = (state_q == ST_RUN) && !reset && load_valid;

    // Byte-offset and high PC bits carry no meaning for a word memory.
    assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

    // Next-state logic: load sequencing, pre-emption and fetch bookkeeping.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        fetch_valid_d = fetch_acc;
        pc_restart_d  = 1'b0;
        boot_done_d   = boot_done_q;
        overflow_d    = overflow_q;
        // Keep the last delivered instruction once the memory output moves on.
        instr_hold_d  = fetch_valid_q ? mem_rdata : instr_hold_q;

        if (load_acc) begin
            count_d = count_q + 1'b1;
        end
        if (load_end) begin
            state_d      = ST_RUN;
            pc_restart_d = 1'b1;
            boot_done_d  = 1'b1;
            if (!load_last) begin
                overflow_d = 1'b1;
            end
        end
        // A new stream in RUN is only noticed here; its first word is taken
        // once back in LOAD, while this cycle's fetch still completes.
        if (reload) begin
            state_d = ST_LOAD;
            count_d = '0;
        end
    end

    // State and registered outputs; reset returns to LOAD without touching memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            count_q       <= '0;
            fetch_valid_q <= 1'b0;
            pc_restart_q  <= 1'b0;
            boot_done_q   <= 1'b0;
            overflow_q    <= 1'b0;
            instr_hold_q  <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            fetch_valid_q <= fetch_valid_d;
            pc_restart_q  <= pc_restart_d;
            boot_done_q   <= boot_done_d;
            overflow_q    <= overflow_d;
            instr_hold_q  <= instr_hold_d;
        end
    end

    // Memory port: loader writes win in LOAD, fetch reads in RUN, else idle at 0.
    always_comb begin
        mem_we    = load_acc;
        mem_wdata = load_acc ? load_data : '0;
        mem_addr  = '0;
        if (load_acc) begin
            mem_addr = wr_ptr;
        end else if (fetch_acc) begin
            mem_addr = fetch_addr[ADDR_W+1:2];
        end
    end

    // The memory's own output register supplies fresh data; otherwise hold.
    assign fetch_instr   = fetch_valid_q ? mem_rdata : instr_hold_q;
    assign fetch_valid   = fetch_valid_q;
    assign cpu_stall     = reset || (state_q == ST_LOAD);
    assign pc_restart    = pc_restart_q;
    assign load_ready    = (state_q == ST_LOAD) && !reset;
    assign load_count    = count_q;
    assign boot_done     = boot_done_q;
    assign load_overflow = overflow_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Bench for imem_load_arbiter: synchronous-read memory model, a reference
// image of the program the loader has streamed, and directed/random steps.
module tb_imem_load_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_valid;
    logic              cpu_stall;
    logic              pc_restart;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W:0]   load_count;
    logic              boot_done;
    logic              load_overflow;

    always #5 clk = ~clk;

    imem_load_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
        .cpu_stall(cpu_stall), .pc_restart(pc_restart),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .load_count(load_count), .boot_done(boot_done), .load_overflow(load_overflow)
    );

    // Single-port memory with one-cycle synchronous read.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    logic [31:0] ref_mem [DEPTH];
    int          tests = 0;
    int          fails = 0;
    logic        prev_req;
    logic [31:0] prev_exp;
    logic [31:0] held;
    logic        exp_ovf;
    logic        directed_boot;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs now reflect the fetch (or lack of one) of the previous cycle.
    task automatic fetch_check();
        if (prev_req) begin
            chk("fetch_valid", fetch_valid, 1);
            chk("fetch_instr", fetch_instr, prev_exp);
            held = prev_exp;
        end else begin
            chk("fetch_idle_valid", fetch_valid, 0);
            chk("fetch_hold", fetch_instr, held);
        end
    endtask

    task automatic fetch_cycle(input logic req, input logic [31:0] addr);
        fetch_check();
        fetch_req  = req;
        fetch_addr = addr;
        load_valid = 1'b0;
        #1;
        chk("fetch_we", mem_we, 0);
        chk("fetch_mem_addr", mem_addr, req ? addr[9:2] : 8'd0);
        chk("run_stall", cpu_stall, 0);
        prev_req = req;
        prev_exp = ref_mem[addr[9:2]];
        tick();
    endtask

    // Streams up to n words (capped at memory depth); the state must already be LOAD.
    task automatic load_prog(input int n, input bit use_last, input bit gapped, input bit expect_end);
        int          nacc;
        logic [31:0] w;
        logic        lst;
        nacc = 0;
        for (int i = 0; i < n && i < DEPTH; i++) begin
            if (gapped) begin
                load_valid = 1'b0;
                load_data  = $urandom;
                fetch_req  = 1'b1;
                fetch_addr = $urandom;
                #1;
                chk("gap_we", mem_we, 0);
                chk("gap_addr", mem_addr, 0);
                chk("gap_count", load_count, i);
                chk("gap_stall", cpu_stall, 1);
                tick();
            end
            w = $urandom;
            if (directed_boot && i == 4) w = 32'h00C42820;
            if (directed_boot && i == 5) w = 32'h00801820;
            lst        = use_last && (i == n - 1);
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = $urandom;
            load_valid = 1'b1;
            load_data  = w;
            load_last  = lst;
            #1;
            chk("ld_ready", load_ready, 1);
            chk("ld_stall", cpu_stall, 1);
            chk("ld_we", mem_we, 1);
            chk("ld_addr", mem_addr, i[7:0]);
            chk("ld_wdata", mem_wdata, w);
            chk("ld_count", load_count, i);
            if (i > 0) begin
                chk("ld_no_fetch", fetch_valid, 0);
                chk("ld_instr_hold", fetch_instr, held);
            end
            ref_mem[i] = w;
            nacc++;
            if (nacc == DEPTH && !lst) exp_ovf = 1'b1;
            tick();
        end
        load_last  = 1'b0;
        load_valid = 1'b0;
        fetch_req  = 1'b0;
        if (expect_end) begin
            chk("end_restart", pc_restart, 1);
            chk("end_stall", cpu_stall, 0);
            chk("end_ready", load_ready, 0);
            chk("end_count", load_count, nacc);
            chk("end_boot", boot_done, 1);
            chk("end_ovf", load_overflow, exp_ovf);
        end
        prev_req = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            mem[k]     = 32'h0;
            ref_mem[k] = 32'h0;
        end
        reset = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h10;
        load_valid = 1'b1; load_data = 32'hDEADBEEF; load_last = 1'b0;
        exp_ovf = 1'b0; held = 32'h0; prev_req = 1'b0; prev_exp = 32'h0;
        directed_boot = 1'b0;

        // Reset state, with loader and fetch both requesting.
        tick(); tick();
        chk("rst_ready", load_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_stall", cpu_stall, 1);
        chk("rst_restart", pc_restart, 0);
        chk("rst_fvalid", fetch_valid, 0);
        chk("rst_instr", fetch_instr, 0);
        chk("rst_count", load_count, 0);
        chk("rst_boot", boot_done, 0);
        chk("rst_ovf", load_overflow, 0);

        // Pre-boot fetch attempts are ignored.
        reset = 1'b0; load_valid = 1'b0;
        #1;
        chk("post_rst_ready", load_ready, 1);
        for (int c = 0; c < 4; c++) begin
            fetch_req = 1'b1; fetch_addr = $urandom;
            #1;
            chk("preboot_addr", mem_addr, 0);
            chk("preboot_we", mem_we, 0);
            chk("preboot_fvalid", fetch_valid, 0);
            chk("preboot_stall", cpu_stall, 1);
            tick();
        end

        // Boot: 14 words, last flagged on word 13.
        directed_boot = 1'b1;
        load_prog(14, 1, 0, 1);
        directed_boot = 1'b0;

        fetch_cycle(1'b1, 32'h10);
        chk("restart_width", pc_restart, 0);
        chk("word4", fetch_instr, 32'h00C42820);
        fetch_cycle(1'b1, 32'h14);
        chk("word5", fetch_instr, 32'h00801820);
        fetch_cycle(1'b1, 32'h13);
        chk("misaligned", fetch_instr, 32'h00C42820);
        fetch_cycle(1'b0, 32'h0);
        for (int c = 0; c < 40; c++) fetch_cycle(1'($urandom_range(0, 1)), $urandom);

        // Reload pre-empting a fetch in the same cycle.
        fetch_check();
        fetch_req = 1'b1; fetch_addr = $urandom; load_valid = 1'b1; load_data = $urandom;
        #1;
        chk("pre_ready", load_ready, 0);
        chk("pre_we", mem_we, 0);
        chk("pre_addr", mem_addr, fetch_addr[9:2]);
        prev_req = 1'b1;
        prev_exp = ref_mem[fetch_addr[9:2]];
        tick();
        fetch_check();
        chk("pre_stall", cpu_stall, 1);
        chk("pre_count", load_count, 0);
        chk("pre_restart", pc_restart, 0);
        load_prog(20, 1, 0, 1);
        for (int c = 0; c < 30; c++) fetch_cycle(1'($urandom_range(0, 1)), $urandom);

        // Overflow: 300 words without a last flag.
        fetch_check();
        fetch_req = 1'b0; load_valid = 1'b1;
        tick();
        prev_req = 1'b0;
        load_prog(300, 0, 0, 1);
        load_valid = 1'b1; load_data = $urandom;
        #1;
        chk("ovf_word256_ready", load_ready, 0);
        chk("ovf_word256_we", mem_we, 0);
        tick();
        chk("ovf_reload_stall", cpu_stall, 1);
        chk("ovf_reload_count", load_count, 0);
        chk("ovf_sticky", load_overflow, 1);
        load_prog(10, 1, 0, 1);
        for (int c = 0; c < 30; c++) fetch_cycle(1'($urandom_range(0, 1)), $urandom);

        // Gapped load interrupted by reset after word 5.
        fetch_check();
        fetch_req = 1'b0; load_valid = 1'b1;
        tick();
        prev_req = 1'b0;
        load_prog(6, 0, 1, 0);
        reset = 1'b1; load_valid = 1'b1;
        #1;
        chk("midrst_ready", load_ready, 0);
        chk("midrst_we", mem_we, 0);
        tick();
        chk("midrst_count", load_count, 0);
        chk("midrst_boot", boot_done, 0);
        chk("midrst_stall", cpu_stall, 1);
        chk("midrst_ovf", load_overflow, 0);
        chk("midrst_fvalid", fetch_valid, 0);
        chk("midrst_instr", fetch_instr, 0);
        exp_ovf = 1'b0; held = 32'h0;
        reset = 1'b0; load_valid = 1'b0;
        load_prog(9, 1, 1, 1);
        for (int c = 0; c < 40; c++) fetch_cycle(1'($urandom_range(0, 1)), $urandom);
        fetch_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
